er_frame_scheduler: RTL and testbench

- Sequences the single-frame error-reconciliation engine over every frame of a sifted-key block.
- Issues one start pulse per frame and waits for completion, with a timeout.
- Collects per-frame leaked-info, error-count and Alice/Bob verification-fail results.
- Keeps block-level totals and raises a single finish pulse. Sits between the top-level start switch and the AB ER datapath.

---
 rtl/er_frame_scheduler_pkg.sv | 24 ++
 rtl/er_sat_accum.sv | 43 ++++
 rtl/er_frame_scheduler.sv | 217 +++++++++++++++++++++
 tb/tb_er_frame_scheduler.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/er_frame_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// er_frame_scheduler_pkg
//   Shared definitions for the error-reconciliation frame scheduler:
//   - scheduler FSM state encoding
//   - default widths for per-frame leaked-info, per-frame error count and
//     block-level totals, matching the frame leaked-info / error-count widths
//     used by the AB ER datapath.
// ----------------------------------------------------------------------------
package er_frame_scheduler_pkg;

    localparam int ER_LEAK_W_DEF = 16;
    localparam int ER_ERR_W_DEF  = 12;
    localparam int ER_TOT_W_DEF  = 24;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACCUM = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } er_state_e;

endpackage

// File: rtl/er_sat_accum.sv
// ----------------------------------------------------------------------------
// er_sat_accum
//   Saturating accumulator with synchronous clear. The addend is zero-extended
//   to the accumulator width and the sum sticks at 2^TOT_W-1.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (accumulator -> 0)
//   clr          synchronous clear (accumulator -> 0), wins over add_en
//   add_en       add add_val this cycle
//   add_val      unsigned addend, IN_W bits
//   acc          accumulated total, TOT_W bits
// ----------------------------------------------------------------------------
module er_sat_accum #(
    parameter int IN_W  = 16,
    parameter int TOT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             add_en,
    input  logic [IN_W-1:0]  add_val,
    output logic [TOT_W-1:0] acc
);

    // One extra bit above the wider operand so the carry is never lost.
    localparam int SUM_W = ((IN_W > TOT_W) ? IN_W : TOT_W) + 1;
    localparam logic [SUM_W-1:0] MAX_VAL = SUM_W'({TOT_W{1'b1}});

    function automatic logic [TOT_W-1:0] sat_add(input logic [TOT_W-1:0] a,
                                                 input logic [IN_W-1:0]  b);
        logic [SUM_W-1:0] s;
        logic [TOT_W-1:0] r;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > MAX_VAL) r = {TOT_W{1'b1}};
        else             r = s[TOT_W-1:0];
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n || clr) acc <= '0;
        else if (add_en)   acc <= sat_add(acc, add_val);
    end

endmodule

// File: rtl/er_frame_scheduler.sv
// ----------------------------------------------------------------------------
// er_frame_scheduler
//   Runs the single-frame error-reconciliation engine over every frame of a
//   sifted-key block: one frame_start pulse per frame, wait for frame_done
//   (bounded by FRAME_TIMEOUT), collect leaked-info / error-count / verify-fail
//   results, keep saturating block totals and pulse finish_all at the end.
//
// Optional build macro: ER_FRAME_RETRY_EN
//   Defined   -> a failing frame (verify fail or timeout) is re-run once with
//                the same frame_idx; adds output retry_count.
//   Undefined -> every failure counts immediately; no retry_count port.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset (aborts a block)
//   start_switch          level; a 0->1 edge starts a block (ignored when busy)
//   frame_start/frame_idx start pulse and index of the current frame
//   frame_done            completion pulse from the engine
//   frame_param_valid     qualifies frame_leaked_info / frame_error_count
//   A_verif_fail/B_verif_fail  verification-fail strobes
//   total_leaked_info/total_error_count  saturating block totals
//   frames_passed/frames_failed          per-block frame counters
//   busy, timeout_err (sticky), finish_all (one-cycle pulse)
//   retry_count           (ER_FRAME_RETRY_EN only) retries this block
// ----------------------------------------------------------------------------
module er_frame_scheduler
    import er_frame_scheduler_pkg::*;
#(
    parameter int NUM_FRAMES    = 8,
    parameter int IDX_W         = 3,
    parameter int LEAK_W        = ER_LEAK_W_DEF,
    parameter int ERR_W         = ER_ERR_W_DEF,
    parameter int TOT_W         = ER_TOT_W_DEF,
    parameter int FRAME_TIMEOUT = 200000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_switch,
    output logic              frame_start,
    output logic [IDX_W-1:0]  frame_idx,
    input  logic              frame_done,
    input  logic              frame_param_valid,
    input  logic [LEAK_W-1:0] frame_leaked_info,
    input  logic [ERR_W-1:0]  frame_error_count,
    input  logic              A_verif_fail,
    input  logic              B_verif_fail,
    output logic [TOT_W-1:0]  total_leaked_info,
    output logic [TOT_W-1:0]  total_error_count,
    output logic [IDX_W:0]    frames_passed,
    output logic [IDX_W:0]    frames_failed,
    output logic              busy,
    output logic              timeout_err,
`ifdef ER_FRAME_RETRY_EN
    output logic [IDX_W:0]    retry_count,
`endif
    output logic              finish_all
);

    localparam int TO_W = (FRAME_TIMEOUT > 2) ? $clog2(FRAME_TIMEOUT) : 1;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(FRAME_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_FRAMES - 1);

    er_state_e         state, state_nxt;
    logic              start_q, armed, start_edge, clr_block;
    logic              valid_seen, fail_latch, frame_ok;
    logic              timeout_hit, fail_event, count_fail, retry_now;
    logic [TO_W-1:0]   tcnt;
    logic [LEAK_W-1:0] leak_q;
    logic [ERR_W-1:0]  err_q;

    // 'armed' only sets after start_switch has been seen low, so a switch
    // held high through reset cannot start a block.
    assign start_edge  = start_switch & ~start_q & armed;
    assign clr_block   = (state == ST_IDLE) && start_edge;
    assign frame_ok    = valid_seen && !fail_latch;
    // frame_done wins over an expiring timeout in the same cycle.
    assign timeout_hit = (state == ST_WAIT) && !frame_done && (tcnt == TO_LAST);
    assign fail_event  = ((state == ST_ACCUM) && !frame_ok) || timeout_hit;

`ifdef ER_FRAME_RETRY_EN
    logic retried, retry_pend, do_retry;

    assign do_retry   = fail_event && !retried;
    assign count_fail = fail_event && retried;
    assign retry_now  = retry_pend;

    always_ff @(posedge clk) begin
        if (!rst_n || clr_block) begin
            retried     <= 1'b0;
            retry_pend  <= 1'b0;
            retry_count <= '0;
        end else begin
            if (do_retry) begin
                retried     <= 1'b1;
                retry_pend  <= 1'b1;
                retry_count <= retry_count + (IDX_W+1)'(1);
            end
            // Leaving NEXT: a pending retry is consumed; otherwise the frame
            // index advances and the next frame gets its own retry.
            if (state == ST_NEXT) begin
                retry_pend <= 1'b0;
                if (!retry_pend) retried <= 1'b0;
            end
        end
    end
`else
    assign count_fail = fail_event;
    assign retry_now  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        finish_all  = 1'b0;
        busy        = (state != ST_IDLE);
        case (state)
            ST_IDLE:  if (start_edge) state_nxt = ST_START;
            ST_START: begin
                frame_start = 1'b1;
                state_nxt   = ST_WAIT;
            end
            ST_WAIT: begin
                if (frame_done)       state_nxt = ST_ACCUM;
                else if (timeout_hit) state_nxt = ST_NEXT;
            end
            ST_ACCUM: state_nxt = ST_NEXT;
            ST_NEXT: begin
                if (retry_now)             state_nxt = ST_START;
                else if (frame_idx == IDX_LAST) state_nxt = ST_DONE;
                else                       state_nxt = ST_START;
            end
            ST_DONE: begin
                finish_all = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_q       <= 1'b0;
            armed         <= 1'b0;
            frame_idx     <= '0;
            frames_passed <= '0;
            frames_failed <= '0;
            timeout_err   <= 1'b0;
            valid_seen    <= 1'b0;
            fail_latch    <= 1'b0;
            tcnt          <= '0;
        end else begin
            start_q <= start_switch;
            armed   <= armed | ~start_switch;
            case (state)
                ST_IDLE: if (start_edge) begin
                    frame_idx     <= '0;
                    frames_passed <= '0;
                    frames_failed <= '0;
                    timeout_err   <= 1'b0;
                end
                ST_START: begin
                    valid_seen <= 1'b0;
                    fail_latch <= 1'b0;
                    tcnt       <= '0;
                end
                ST_WAIT: begin
                    tcnt <= tcnt + TO_W'(1);
                    if (frame_param_valid)           valid_seen  <= 1'b1;
                    if (A_verif_fail | B_verif_fail) fail_latch  <= 1'b1;
                    if (timeout_hit)                 timeout_err <= 1'b1;
                end
                ST_ACCUM: if (frame_ok) frames_passed <= frames_passed + (IDX_W+1)'(1);
                ST_NEXT:  if (!retry_now && frame_idx != IDX_LAST)
                              frame_idx <= frame_idx + IDX_W'(1);
                default: ;
            endcase
            if (count_fail) frames_failed <= frames_failed + (IDX_W+1)'(1);
        end
    end

    // Per-frame result latches; cleared at START so a frame that never
    // delivers parameters contributes nothing.
    always_ff @(posedge clk) begin
        if (state == ST_START) begin
            leak_q <= '0;
            err_q  <= '0;
        end else if (state == ST_WAIT && frame_param_valid) begin
            leak_q <= frame_leaked_info;
            err_q  <= frame_error_count;
        end
    end

    // Leaked info counts whenever parameters arrived: it was disclosed on the
    // channel whether or not the frame verified.
    er_sat_accum #(.IN_W(LEAK_W), .TOT_W(TOT_W)) u_leak_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr_block),
        .add_en  ((state == ST_ACCUM) && valid_seen),
        .add_val (leak_q),
        .acc     (total_leaked_info)
    );

    er_sat_accum #(.IN_W(ERR_W), .TOT_W(TOT_W)) u_err_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr_block),
        .add_en  ((state == ST_ACCUM) && frame_ok),
        .add_val (err_q),
        .acc     (total_error_count)
    );

endmodule

// File: tb/tb_er_frame_scheduler.sv
// ----------------------------------------------------------------------------
// tb_er_frame_scheduler
//   Testbench for er_frame_scheduler. A behavioural ER engine answers each
//   frame_start from a per-frame configuration table; a reference model
//   computes the expected block results, which are queued when a block is
//   launched and popped when finish_all arrives. A second instance with
//   TOT_W=8 shares the stimulus to exercise total saturation.
//   Honours ER_FRAME_RETRY_EN (retry_count port, retry expectations).
// ----------------------------------------------------------------------------
module tb_er_frame_scheduler;

    localparam int NUM_FRAMES    = 8;
    localparam int IDX_W         = 3;
    localparam int LEAK_W        = 16;
    localparam int ERR_W         = 12;
    localparam int TOT_W         = 24;
    localparam int SAT_TOT_W     = 8;
    localparam int FRAME_TIMEOUT = 50;
`ifdef ER_FRAME_RETRY_EN
    localparam int MAX_ATT = 2;
`else
    localparam int MAX_ATT = 1;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_switch = 1'b0;
    logic              frame_done = 1'b0;
    logic              frame_param_valid = 1'b0;
    logic [LEAK_W-1:0] frame_leaked_info = '0;
    logic [ERR_W-1:0]  frame_error_count = '0;
    logic              A_verif_fail = 1'b0;
    logic              B_verif_fail = 1'b0;

    logic              frame_start, busy, timeout_err, finish_all;
    logic [IDX_W-1:0]  frame_idx;
    logic [TOT_W-1:0]  total_leaked_info, total_error_count;
    logic [IDX_W:0]    frames_passed, frames_failed;

    logic                 s_frame_start, s_busy, s_timeout_err, s_finish_all;
    logic [IDX_W-1:0]     s_frame_idx;
    logic [SAT_TOT_W-1:0] s_total_leaked, s_total_err;
    logic [IDX_W:0]       s_passed, s_failed;
`ifdef ER_FRAME_RETRY_EN
    logic [IDX_W:0]       retry_count, s_retry_count;
`endif

    always #5 clk = ~clk;

    er_frame_scheduler #(
        .NUM_FRAMES(NUM_FRAMES), .IDX_W(IDX_W), .LEAK_W(LEAK_W), .ERR_W(ERR_W),
        .TOT_W(TOT_W), .FRAME_TIMEOUT(FRAME_TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_switch(start_switch),
        .frame_start(frame_start), .frame_idx(frame_idx), .frame_done(frame_done),
        .frame_param_valid(frame_param_valid), .frame_leaked_info(frame_leaked_info),
        .frame_error_count(frame_error_count), .A_verif_fail(A_verif_fail),
        .B_verif_fail(B_verif_fail), .total_leaked_info(total_leaked_info),
        .total_error_count(total_error_count), .frames_passed(frames_passed),
        .frames_failed(frames_failed), .busy(busy), .timeout_err(timeout_err),
`ifdef ER_FRAME_RETRY_EN
        .retry_count(retry_count),
`endif
        .finish_all(finish_all)
    );

    er_frame_scheduler #(
        .NUM_FRAMES(NUM_FRAMES), .IDX_W(IDX_W), .LEAK_W(LEAK_W), .ERR_W(ERR_W),
        .TOT_W(SAT_TOT_W), .FRAME_TIMEOUT(FRAME_TIMEOUT)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .start_switch(start_switch),
        .frame_start(s_frame_start), .frame_idx(s_frame_idx), .frame_done(frame_done),
        .frame_param_valid(frame_param_valid), .frame_leaked_info(frame_leaked_info),
        .frame_error_count(frame_error_count), .A_verif_fail(A_verif_fail),
        .B_verif_fail(B_verif_fail), .total_leaked_info(s_total_leaked),
        .total_error_count(s_total_err), .frames_passed(s_passed),
        .frames_failed(s_failed), .busy(s_busy), .timeout_err(s_timeout_err),
`ifdef ER_FRAME_RETRY_EN
        .retry_count(s_retry_count),
`endif
        .finish_all(s_finish_all)
    );

    typedef struct {
        longint leak;
        longint err;
        longint sat_leak;
        int     passed;
        int     failed;
        int     starts;
        int     retries;
        bit     tmo;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_e;

    int  n_checks = 0;
    int  n_errors = 0;

    int  cfg_leak[NUM_FRAMES];
    int  cfg_err[NUM_FRAMES];
    bit  cfg_afail[NUM_FRAMES];
    bit  cfg_bfail[NUM_FRAMES];
    bit  cfg_stall[NUM_FRAMES];
    bit  cfg_fail_once[NUM_FRAMES];
    int  att[NUM_FRAMES];

    int  cyc = 0, last_fs = 0, fs_cnt = 0, fin_cnt = 0, to_delta = -1;
    bit  to_prev = 1'b0;

    // Monitor: counts start/finish pulses and times the timeout_err rise.
    initial begin : monitor
        forever begin
            @(negedge clk);
            cyc++;
            if (frame_start) begin
                fs_cnt++;
                last_fs = cyc;
            end
            if (finish_all) fin_cnt++;
            if (timeout_err && !to_prev && to_delta < 0) to_delta = cyc - last_fs;
            to_prev = timeout_err;
        end
    end

    // Behavioural ER engine.
    initial begin : engine
        int idx;
        forever begin
            @(negedge clk);
            if (rst_n && frame_start) begin
                idx = int'(frame_idx);
                att[idx]++;
                if (!cfg_stall[idx]) begin
                    repeat (2) @(negedge clk);
                    frame_param_valid = 1'b1;
                    frame_leaked_info = LEAK_W'(cfg_leak[idx]);
                    frame_error_count = ERR_W'(cfg_err[idx]);
                    @(negedge clk);
                    frame_param_valid = 1'b0;
                    repeat (2) @(negedge clk);
                    A_verif_fail = cfg_afail[idx] || (cfg_fail_once[idx] && att[idx] == 1);
                    B_verif_fail = cfg_bfail[idx];
                    frame_done   = 1'b1;
                    @(negedge clk);
                    frame_done   = 1'b0;
                    A_verif_fail = 1'b0;
                    B_verif_fail = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded 50000 cycles");
        $fatal(1, "watchdog");
    end

    function automatic longint sat_to(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic exp_t model();
        exp_t e;
        bit   done_f, fail_a;
        e = '{default: 0};
        for (int f = 0; f < NUM_FRAMES; f++) begin
            done_f = 1'b0;
            for (int a = 0; a < MAX_ATT && !done_f; a++) begin
                fail_a = cfg_stall[f] || cfg_afail[f] || cfg_bfail[f] ||
                         (cfg_fail_once[f] && a == 0);
                e.starts++;
                if (cfg_stall[f]) e.tmo = 1'b1;
                else begin
                    e.leak     = sat_to(e.leak + cfg_leak[f], TOT_W);
                    e.sat_leak = sat_to(e.sat_leak + cfg_leak[f], SAT_TOT_W);
                end
                if (!fail_a) begin
                    e.err = sat_to(e.err + cfg_err[f], TOT_W);
                    e.passed++;
                    done_f = 1'b1;
                end else if (a == MAX_ATT - 1) begin
                    e.failed++;
                    done_f = 1'b1;
                end else begin
                    e.retries++;
                end
            end
        end
        return e;
    endfunction

    task automatic set_cfg(input int leak, input int err);
        for (int i = 0; i < NUM_FRAMES; i++) begin
            cfg_leak[i] = leak;      cfg_err[i] = err;
            cfg_afail[i] = 1'b0;     cfg_bfail[i] = 1'b0;
            cfg_stall[i] = 1'b0;     cfg_fail_once[i] = 1'b0;
        end
    endtask

    // Launch one block, queue its expected result, wait for finish_all and
    // compare against the popped expectation.
    task automatic run_block(input string name);
        exp_t e;
        int   n, fs0, fin0;
        exp_q.push_back(model());
        for (int i = 0; i < NUM_FRAMES; i++) att[i] = 0;
        fs0  = fs_cnt;
        fin0 = fin_cnt;
        start_switch = 1'b0;
        @(negedge clk);
        start_switch = 1'b1;
        n = 0;
        while (fin_cnt == fin0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        e = exp_q.pop_front();
        last_e = e;
        n_checks++;
        if (fin_cnt - fin0 != 1) begin
            n_errors++;
            $display("FAIL %s finish_count: got %0d pulses, expected 1", name, fin_cnt - fin0);
        end
        n_checks++;
        if (total_leaked_info !== TOT_W'(e.leak)) begin
            n_errors++;
            $display("FAIL %s total_leaked: got %0d expected %0d", name, total_leaked_info, e.leak);
        end
        n_checks++;
        if (total_error_count !== TOT_W'(e.err)) begin
            n_errors++;
            $display("FAIL %s total_err: got %0d expected %0d", name, total_error_count, e.err);
        end
        n_checks++;
        if (frames_passed !== (IDX_W+1)'(e.passed)) begin
            n_errors++;
            $display("FAIL %s passed: got %0d expected %0d", name, frames_passed, e.passed);
        end
        n_checks++;
        if (frames_failed !== (IDX_W+1)'(e.failed)) begin
            n_errors++;
            $display("FAIL %s failed: got %0d expected %0d", name, frames_failed, e.failed);
        end
        n_checks++;
        if (int'(frames_passed) + int'(frames_failed) != NUM_FRAMES) begin
            n_errors++;
            $display("FAIL %s invariant: passed+failed=%0d expected %0d", name,
                     int'(frames_passed) + int'(frames_failed), NUM_FRAMES);
        end
        n_checks++;
        if (timeout_err !== e.tmo) begin
            n_errors++;
            $display("FAIL %s timeout_err: got %0b expected %0b", name, timeout_err, e.tmo);
        end
        n_checks++;
        if (fs_cnt - fs0 != e.starts) begin
            n_errors++;
            $display("FAIL %s frame_starts: got %0d expected %0d", name, fs_cnt - fs0, e.starts);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s busy_after: got %0b expected 0", name, busy);
        end
        n_checks++;
        if (s_total_leaked !== SAT_TOT_W'(e.sat_leak)) begin
            n_errors++;
            $display("FAIL %s sat_total_leaked: got %0d expected %0d", name, s_total_leaked, e.sat_leak);
        end
`ifdef ER_FRAME_RETRY_EN
        n_checks++;
        if (retry_count !== (IDX_W+1)'(e.retries)) begin
            n_errors++;
            $display("FAIL %s retry_count: got %0d expected %0d", name, retry_count, e.retries);
        end
`endif
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({frame_start, busy, timeout_err, finish_all, frame_idx} !== '0) begin
            n_errors++;
            $display("FAIL reset_ctrl: got start=%0b busy=%0b tmo=%0b fin=%0b idx=%0d, expected all 0",
                     frame_start, busy, timeout_err, finish_all, frame_idx);
        end
        n_checks++;
        if ({total_leaked_info, total_error_count, frames_passed, frames_failed} !== '0) begin
            n_errors++;
            $display("FAIL reset_totals: got leak=%0d err=%0d pass=%0d fail=%0d, expected 0",
                     total_leaked_info, total_error_count, frames_passed, frames_failed);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || fs_cnt != 0) begin
            n_errors++;
            $display("FAIL reset_idle: got busy=%0b starts=%0d, expected 0/0", busy, fs_cnt);
        end
    endtask

    // All frames pass; a start edge while busy must be ignored.
    task automatic test_all_pass();
        set_cfg(100, 5);
        fork
            run_block("all_pass");
            begin
                repeat (30) @(negedge clk);
                n_checks++;
                if (busy !== 1'b1) begin
                    n_errors++;
                    $display("FAIL busy_mid: got %0b expected 1", busy);
                end
                start_switch = 1'b0;
                repeat (2) @(negedge clk);
                start_switch = 1'b1;
            end
        join
    endtask

    task automatic test_verif_fail();
        set_cfg(100, 5);
        cfg_afail[3] = 1'b1;
        run_block("a_fail_f3");
        set_cfg(60, 7);
        cfg_bfail[0] = 1'b1;
        run_block("b_fail_f0");
    endtask

    task automatic test_timeout();
        set_cfg(100, 5);
        cfg_stall[2] = 1'b1;
        to_delta = -1;
        run_block("timeout_f2");
        // Rises at the end of WAIT cycle FRAME_TIMEOUT, i.e. seen on the
        // (FRAME_TIMEOUT+1)-th falling edge after the START cycle.
        n_checks++;
        if (to_delta != FRAME_TIMEOUT + 1) begin
            n_errors++;
            $display("FAIL timeout_latency: got %0d expected %0d", to_delta, FRAME_TIMEOUT + 1);
        end
    endtask

    task automatic test_saturation();
        set_cfg(200, 9);
        run_block("saturation");
    endtask

    task automatic test_stray();
        int fin0;
        fin0 = fin_cnt;
        frame_param_valid = 1'b1;
        frame_leaked_info = 16'd999;
        frame_error_count = 12'd77;
        A_verif_fail      = 1'b1;
        frame_done        = 1'b1;
        @(negedge clk);
        frame_param_valid = 1'b0;
        A_verif_fail      = 1'b0;
        frame_done        = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (total_leaked_info !== TOT_W'(last_e.leak) || total_error_count !== TOT_W'(last_e.err)) begin
            n_errors++;
            $display("FAIL stray_totals: got leak=%0d err=%0d expected %0d/%0d",
                     total_leaked_info, total_error_count, last_e.leak, last_e.err);
        end
        n_checks++;
        if (frames_passed !== (IDX_W+1)'(last_e.passed) || busy !== 1'b0 || fin_cnt != fin0) begin
            n_errors++;
            $display("FAIL stray_state: got pass=%0d busy=%0b fin=%0d expected %0d/0/0",
                     frames_passed, busy, fin_cnt - fin0, last_e.passed);
        end
    endtask

    task automatic test_reset_midblock();
        int n, fs0, fin0;
        set_cfg(100, 5);
        for (int i = 0; i < NUM_FRAMES; i++) att[i] = 0;
        fs0  = fs_cnt;
        fin0 = fin_cnt;
        start_switch = 1'b0;
        @(negedge clk);
        start_switch = 1'b1;
        n = 0;
        while (fs_cnt < fs0 + 5 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (frame_idx !== IDX_W'(4) || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL midblock_pos: got idx=%0d busy=%0b expected 4/1", frame_idx, busy);
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({frame_start, busy, timeout_err, finish_all, frame_idx, total_leaked_info,
             total_error_count, frames_passed, frames_failed} !== '0) begin
            n_errors++;
            $display("FAIL midblock_reset: got busy=%0b idx=%0d leak=%0d err=%0d pass=%0d, expected all 0",
                     busy, frame_idx, total_leaked_info, total_error_count, frames_passed);
        end
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || fs_cnt != fs0 + 5 || fin_cnt != fin0) begin
            n_errors++;
            $display("FAIL held_start: got busy=%0b new_starts=%0d finishes=%0d expected 0/0/0",
                     busy, fs_cnt - fs0 - 5, fin_cnt - fin0);
        end
        run_block("after_reset");
    endtask

    task automatic test_retry();
        set_cfg(100, 5);
        cfg_fail_once[1] = 1'b1;
        run_block("fail_once_f1");
    endtask

    initial begin : main
        test_reset();
        test_all_pass();
        test_verif_fail();
        test_timeout();
        test_saturation();
        test_stray();
        test_reset_midblock();
        test_retry();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
